// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_sched_ctrl
// Description : Command sequencer for key_expansion and the AES-128 round
//               datapath. Accepts LOAD_KEY / ENCRYPT / DECRYPT commands,
//               emits the single-cycle key_expansion step pulses, drives the
//               round strobes and reports completion over a done handshake.
//               Optional build macro AES_KEY_SCHED_AUTO_PREP_EN: a DECRYPT
//               issued without a valid schedule first walks the schedule
//               forward instead of being rejected.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_sched_ctrl #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic             ke_set_new_key,
  output logic             ke_start_enc,
  output logic             ke_ready_enc,
  output logic             ke_start_dec,
  output logic             ke_ready_dec,
  output logic             dp_round_en,
  output logic [IDX_W-1:0] dp_round_idx,
  output logic             dp_final,
  output logic             dp_dec,
  output logic             sched_valid,
  output logic             busy,
  output logic             done_valid,
  output logic             done_err,
  input  logic             done_ready
);

  localparam logic [1:0]       c_op_enc  = 2'b00;
  localparam logic [1:0]       c_op_dec  = 2'b01;
  localparam logic [1:0]       c_op_load = 2'b10;
  localparam logic [IDX_W-1:0] c_last    = IDX_W'(NR);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD       = 4'd1,
    S_PREP_START = 4'd2,
    S_PREP_STEP  = 4'd3,
    S_PREP_GAP   = 4'd4,
    S_START      = 4'd5,
    S_EXEC       = 4'd6,
    S_STEP       = 4'd7,
    S_DONE       = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_round;
  logic             r_dec;
  logic             r_err;
  logic             r_sched_valid;
  logic             r_run;
  logic             w_accept;
  logic             w_last;
  logic             w_rejected;

  // Holds cmd_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  assign cmd_ready = r_run & (r_state == S_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_last    = (r_round == c_last);

`ifdef AES_KEY_SCHED_AUTO_PREP_EN
  assign w_rejected = (cmd_op == 2'b11);
`else
  assign w_rejected = (cmd_op == 2'b11) | ((cmd_op == c_op_dec) & ~r_sched_valid);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; the final EXEC presents completion together with the
  // last round so a ready consumer can retire without an extra DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (cmd_op == c_op_load)     w_next = S_LOAD;
          else if (w_rejected)         w_next = S_DONE;
          else if (cmd_op == c_op_enc) w_next = S_START;
          else if (r_sched_valid)      w_next = S_START;
          else                         w_next = S_PREP_START;
        end
      end
      S_LOAD:       w_next = S_DONE;
      S_PREP_START: w_next = S_PREP_STEP;
      S_PREP_STEP:  w_next = S_PREP_GAP;
      S_PREP_GAP:   w_next = w_last ? S_START : S_PREP_STEP;
      S_START:      w_next = S_EXEC;
      S_EXEC: begin
        if (!w_last)         w_next = S_STEP;
        else if (done_ready) w_next = S_IDLE;
        else                 w_next = S_DONE;
      end
      S_STEP:       w_next = S_EXEC;
      S_DONE:       w_next = done_ready ? S_IDLE : S_DONE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Round counter: cleared at the start of a walk, advanced on each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_round <= '0;
    end else begin
      case (r_state)
        S_START, S_PREP_START: r_round <= '0;
        S_STEP, S_PREP_STEP:   r_round <= r_round + IDX_W'(1);
        default:               r_round <= r_round;
      endcase
    end
  end

  // Operation attributes captured when a command is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec <= 1'b0;
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_dec <= (cmd_op == c_op_dec);
      r_err <= w_rejected;
    end
  end

  // Schedule validity: dropped on key load, set once a full walk completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sched_valid <= 1'b0;
    end else if (w_accept && (cmd_op == c_op_load)) begin
      r_sched_valid <= 1'b0;
    end else if (w_last && ((r_state == S_EXEC) || (r_state == S_PREP_GAP))) begin
      r_sched_valid <= 1'b1;
    end
  end

  assign ke_set_new_key = (r_state == S_LOAD);
  assign ke_start_enc   = ((r_state == S_START) & ~r_dec) | (r_state == S_PREP_START);
  assign ke_ready_enc   = ((r_state == S_STEP) & ~r_dec) | (r_state == S_PREP_STEP);
  assign ke_start_dec   = (r_state == S_START) & r_dec;
  assign ke_ready_dec   = (r_state == S_STEP) & r_dec;

  assign dp_round_en  = (r_state == S_EXEC);
  assign dp_round_idx = dp_round_en ? r_round : '0;
  assign dp_final     = dp_round_en & w_last;
  assign dp_dec       = r_dec & ((r_state == S_START) | (r_state == S_EXEC) | (r_state == S_STEP));

  assign sched_valid = r_sched_valid;
  assign busy        = (r_state != S_IDLE);
  assign done_valid  = (r_state == S_DONE) | dp_final;
  assign done_err    = (r_state == S_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_sched_ctrl
// Description : Scoreboard bench for aes_key_sched_ctrl. Expected completions
//               come from an operation-level model; a monitor tracks the key
//               round position implied by the key_expansion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_key_sched_ctrl;

  localparam int         NR      = 10;
  localparam int         IDX_W   = 4;
  localparam logic [1:0] OP_ENC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_op = 2'b00;
  logic             cmd_ready;
  logic             ke_set_new_key, ke_start_enc, ke_ready_enc, ke_start_dec, ke_ready_dec;
  logic             dp_round_en;
  logic [IDX_W-1:0] dp_round_idx;
  logic             dp_final, dp_dec, sched_valid, busy, done_valid, done_err;
  logic             done_ready = 1'b0;

  aes_key_sched_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .ke_set_new_key(ke_set_new_key), .ke_start_enc(ke_start_enc), .ke_ready_enc(ke_ready_enc),
    .ke_start_dec(ke_start_dec), .ke_ready_dec(ke_ready_dec),
    .dp_round_en(dp_round_en), .dp_round_idx(dp_round_idx), .dp_final(dp_final), .dp_dec(dp_dec),
    .sched_valid(sched_valid), .busy(busy), .done_valid(done_valid), .done_err(done_err),
    .done_ready(done_ready)
  );

  typedef struct {
    int lat;
    bit err;
    int n_set, n_se, n_re, n_sd, n_rd, n_rnd;
    bit sv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   sv_model = 1'b0;
  bit   hold = 1'b0;

  // monitor state
  bit   active = 1'b0, got_done = 1'b0, post = 1'b0, mon_dec = 1'b0, prev_rdy = 1'b0;
  exp_t cur;
  int   t0 = 0, hs_cyc = -100, acc_cyc = 0, exp_idx = 0, key_pos = 0;
  int   n_set, n_se, n_re, n_sd, n_rd, n_rnd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Operation-level reference: what each command must produce.
  function automatic exp_t model(input logic [1:0] op, input bit sv);
    exp_t e;
    e = '{default: 0};
    case (op)
      OP_LOAD: begin e.lat = 2; e.n_set = 1; e.sv = 1'b0; end
      OP_ENC:  begin e.lat = 2*NR + 2; e.n_se = 1; e.n_re = NR; e.n_rnd = NR + 1; e.sv = 1'b1; end
      OP_DEC: begin
        if (sv) begin
          e.lat = 2*NR + 2; e.n_sd = 1; e.n_rd = NR; e.n_rnd = NR + 1; e.sv = 1'b1;
        end else begin
`ifdef AES_KEY_SCHED_AUTO_PREP_EN
          e.lat = 4*NR + 3; e.n_se = 1; e.n_re = NR; e.n_sd = 1; e.n_rd = NR;
          e.n_rnd = NR + 1; e.sv = 1'b1;
`else
          e.lat = 1; e.err = 1'b1; e.sv = 1'b0;
`endif
        end
      end
      default: begin e.lat = 1; e.err = 1'b1; e.sv = sv; end
    endcase
    return e;
  endfunction

  // Consumer: random backpressure unless a hold is requested.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      done_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: tracks each operation from accept to done handshake.
  initial begin
    int nke;
    bit rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0; got_done = 0; post = 0; prev_rdy = 0;
      end else begin
        if (post) begin
          check("sched_valid_after_done", sched_valid, cur.sv);
          check("cmd_ready_after_done", cmd_ready, 1);
          post = 0;
        end
        if (active && got_done) begin
          if (done_valid && done_ready) begin
            hs_cyc = cyc; active = 0; got_done = 0; post = 1;
          end
        end else if (cmd_valid && cmd_ready) begin
          active = 1; got_done = 0; t0 = cyc; mon_dec = (cmd_op == OP_DEC);
          n_set = 0; n_se = 0; n_re = 0; n_sd = 0; n_rd = 0; n_rnd = 0;
          exp_idx = 0; prev_rdy = 0;
        end else if (active) begin
          nke = int'(ke_set_new_key) + int'(ke_start_enc) + int'(ke_ready_enc)
              + int'(ke_start_dec) + int'(ke_ready_dec);
          check("ke_onehot", int'(nke <= 1), 1);
          rdy = ke_ready_enc | ke_ready_dec;
          check("ready_low_gap", int'(rdy && prev_rdy), 0);
          prev_rdy = rdy;
          check("dp_final", dp_final, int'(dp_round_en && (dp_round_idx == NR)));
          if (dp_round_en) begin
            check("round_idx", dp_round_idx, exp_idx);
            check("round_key", key_pos, mon_dec ? NR - exp_idx : exp_idx);
            check("dp_dec", dp_dec, mon_dec);
            exp_idx++; n_rnd++;
          end
          if (ke_set_new_key) begin n_set++; key_pos = 0;  end
          if (ke_start_enc)   begin n_se++;  key_pos = 0;  end
          if (ke_ready_enc)   begin n_re++;  key_pos++;    end
          if (ke_start_dec)   begin n_sd++;  key_pos = NR; end
          if (ke_ready_dec)   begin n_rd++;  key_pos--;    end
          if (done_valid) begin
            got_done = 1;
            if (q.size() == 0) begin
              check("unexpected_done", 1, 0);
            end else begin
              cur = q.pop_front();
              check("latency", cyc - t0, cur.lat);
              check("done_err", done_err, cur.err);
              check("n_set_new_key", n_set, cur.n_set);
              check("n_start_enc", n_se, cur.n_se);
              check("n_ready_enc", n_re, cur.n_re);
              check("n_start_dec", n_sd, cur.n_sd);
              check("n_ready_dec", n_rd, cur.n_rd);
              check("n_rounds", n_rnd, cur.n_rnd);
            end
            if (done_ready) begin
              hs_cyc = cyc; active = 0; got_done = 0; post = 1;
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [1:0] op);
    bit   ok;
    exp_t e;
    ok = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1;
        acc_cyc = cyc;
        e = model(op, sv_model);
        q.push_back(e);
        sv_model = e.sv;
        break;
      end
    end
    if (!ok) check("cmd_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !active && !post) begin ok = 1; break; end
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 0);
    check({tag, "_ke_any"}, int'(ke_set_new_key | ke_start_enc | ke_ready_enc | ke_start_dec | ke_ready_dec), 0);
    check({tag, "_dp_any"}, int'(dp_round_en | dp_final | dp_dec), 0);
    check({tag, "_dp_round_idx"}, dp_round_idx, 0);
    check({tag, "_sched_valid"}, sched_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, int'(done_valid | done_err), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         ok;
    logic [1:0] op;
    int         r;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);

    // directed sequence
    issue(OP_LOAD); wait_done();
    issue(OP_ENC);  wait_done();
    issue(OP_DEC);  wait_done();
    issue(OP_LOAD); wait_done();
    issue(OP_DEC);  wait_done();
    issue(OP_RSV);  wait_done();

    // done held off: no new command may be accepted meanwhile
    hold = 1'b1;
    issue(OP_ENC);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_valid) begin ok = 1; break; end
    end
    if (!ok) check("hold_done_timeout", 0, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    repeat (5) begin
      @(negedge clk);
      check("hold_done_valid", done_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    hold = 1'b0;
    issue(OP_LOAD);
    check("accept_after_handshake", acc_cyc, hs_cyc + 1);
    wait_done();

    // reset during round 4 of an encryption
    issue(OP_ENC);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (dp_round_en && dp_round_idx == 4) begin ok = 1; break; end
    end
    if (!ok) check("round4_timeout", 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    sv_model = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("post_reset_sched_valid", sched_valid, 0);
    issue(OP_LOAD); wait_done();
    issue(OP_ENC);  wait_done();

    // randomized command stream
    for (int n = 0; n < 30; n++) begin
      r  = $urandom_range(0, 9);
      op = (r < 3) ? OP_ENC : (r < 6) ? OP_DEC : (r < 8) ? OP_LOAD : OP_RSV;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      issue(op);
      wait_done();
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Sequencer for key_expansion and the AES-128 round datapath.
- Accepts LOAD_KEY / ENCRYPT / DECRYPT commands over a valid/ready handshake.
- Generates the single-cycle set_new_key / start_* / ready_* step pulses that key_expansion needs, and tracks schedule validity.
- Drives round-enable, round index and final-round strobes to the cipher datapath, and returns completion over a done handshake.

Parameters:
- NR, 10, number of cipher rounds; the round index runs 0..NR.
- IDX_W, 4, width of dp_round_idx; must satisfy 2^IDX_W > NR.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  2  command: 00 = ENCRYPT, 01 = DECRYPT, 10 = LOAD_KEY, 11 = reserved.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid & cmd_ready.
- ke_set_new_key  out  1  to key_expansion.set_new_key.
- ke_start_enc  out  1  to key_expansion.start_enc.
- ke_ready_enc  out  1  to key_expansion.ready_enc (rising edge = one forward step).
- ke_start_dec  out  1  to key_expansion.start_dec.
- ke_ready_dec  out  1  to key_expansion.ready_dec (rising edge = one backward step).
- dp_round_en  out  1  datapath performs round dp_round_idx this cycle.
- dp_round_idx  out  IDX_W  current round, 0..NR.
- dp_final  out  1  dp_round_en for round NR.
- dp_dec  out  1  current operation is decryption.
- sched_valid  out  1  full schedule has been generated since the last key load.
- busy  out  1  FSM not in IDLE.
- done_valid  out  1  operation complete.
- done_err  out  1  qualifies done_valid; operation rejected.
- done_ready  in  1  consumer accepts done.

Behaviour:
- Reset: every output is 0, FSM goes to IDLE, round counter is 0.
- cmd_ready = 1 only in IDLE.
- Commands take effect in the cycle after acceptance.
- FSM states: IDLE, LOAD, PREP_START, PREP_STEP, PREP_GAP, START, EXEC, STEP, DONE.
- LOAD_KEY: LOAD for one cycle with ke_set_new_key = 1, sched_valid cleared to 0, then DONE (done_err = 0).
- ENCRYPT:
  - START for one cycle with ke_start_enc = 1.
  - EXEC: dp_round_en = 1, dp_round_idx = r. If r < NR, go to STEP; otherwise go to DONE.
  - STEP: ke_ready_enc = 1 for one cycle, r++, back to EXEC.
  - The EXEC cycle between steps is the mandatory low gap of ready_* (high 1 cycle, low ≥ 1 cycle).
  - On the r = NR EXEC, sched_valid is set to 1.
- DECRYPT, sched_valid = 1: START pulses ke_start_dec, then the same EXEC/STEP loop using ke_ready_dec. dp_dec = 1 and dp_round_idx reports logical rounds 0..NR; the key presented is round NR - idx.
- DECRYPT, sched_valid = 0: handled per the Optional Feature below.
- dp_final = dp_round_en & (r == NR).
- Latency from the accept cycle (T) to done_valid rising:
  - LOAD_KEY: T + 2.
  - ENCRYPT, and DECRYPT with a valid schedule: T + 2·NR + 2 (22 cycles for NR = 10).
- DONE: done_valid (and done_err) held until done_valid & done_ready. Then return to IDLE; cmd_ready rises the following cycle.
- Reserved op 11: DONE with done_err = 1, no key_expansion pulses, sched_valid unchanged.
- At most one ke_* output is high in any cycle.
- The round counter never exceeds NR; no wrap-around.
- Reset mid-operation: all pulses drop immediately, sched_valid = 0, and any pending done is discarded.
- An aborted ENCRYPT or PREP never sets sched_valid.

Optional Feature:
- Macro: AES_KEY_SCHED_AUTO_PREP_EN.
- Defined: DECRYPT with sched_valid = 0 first runs a warm-up walk:
  - PREP_START: ke_start_enc for one cycle.
  - Then NR × (PREP_STEP: ke_ready_enc = 1; PREP_GAP: all low).
  - sched_valid is set, then the normal decrypt path follows.
  - No dp_round_en during warm-up.
  - Added latency: 2·NR + 1 cycles (total T + 4·NR + 3).
- Undefined: DECRYPT with sched_valid = 0 goes straight to DONE with done_err = 1 at T + 1, with no ke_* or dp_* activity.

Test Plan:
- Reset, then LOAD_KEY → ke_set_new_key pulses once at T+1; done_valid at T+2, done_err = 0; sched_valid = 0; key_enc = 000102030405060708090a0b0c0d0e0f.
- ENCRYPT after load → exactly 10 ke_ready_enc pulses, each followed by a low cycle; dp_round_en is high 11 times with idx 0..10; dp_final only on idx 10; done_valid at T+22; key_enc = 13111d7fe3944a17f307a78b4d2b30c5; sched_valid = 1.
- DECRYPT with schedule valid → ke_start_dec at T+1; 10 ke_ready_dec pulses; final key_dec = 000102030405060708090a0b0c0d0e0f; dp_dec = 1 throughout; done_valid at T+22.
- LOAD_KEY then DECRYPT:
  - With AUTO_PREP_EN: 10 warm-up ke_ready_enc pulses with no dp_round_en, then normal decrypt; done_valid at T+43.
  - Without AUTO_PREP_EN: done_err = 1 at T+1 with no pulses.
- Hold done_ready = 0 for 5 cycles → done_valid stays high, cmd_ready stays 0; a cmd_valid presented meanwhile is not accepted until the cycle after the done handshake.
- Assert rst_n = 0 during round 4 of ENCRYPT → all outputs 0 asynchronously, sched_valid = 0; after release, cmd_ready = 1 and a fresh LOAD_KEY + ENCRYPT completes normally.
